lin_rec_gen: RTL and testbench

Synchronous, parametrised linear-recurrence sequence generator. It is the clocked successor of the fixed two-term asynchronous Fibonacci loop. The block supports recurrence order 2..4 (Fibonacci, tribonacci, tetranacci), run-time seeds, a programmable term count, overflow detection with a wrap or stop policy, and a valid/ready output stream. It feeds downstream sinks or test pattern consumers in the same way the dual-rail generator feeds its output link.

---
 rtl/lin_rec_gen.sv | 137 +++++++++++++
 tb/tb_lin_rec_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lin_rec_gen.sv
// Clocked linear-recurrence sequence generator (order 2..4) with run-time seeds,
// programmable term count, wrap/stop overflow policy and a valid/ready output stream.
module lin_rec_gen #(
    parameter int WIDTH = 32,
    parameter int ORDER = 2,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ORDER*WIDTH-1:0] seed_i,
    input  logic [CNT_W-1:0]       len_i,
    input  logic                   mode_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic                   ovf
);

    generate
        if (ORDER < 2 || ORDER > 4) begin : g_bad_order
            $error("lin_rec_gen: ORDER must be in the range 2..4");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] ORDER_C = CNT_W'(ORDER);
    localparam logic [CNT_W-1:0] HIST_C  = CNT_W'(ORDER - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] h [ORDER];
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_dec;
    logic [CNT_W-1:0] cnt_clamp;
    logic             mode;
    logic             ovf_r;
    logic             done_r;
    logic [WIDTH+1:0] sum;
    logic             sum_ovf;
    logic             hs;
    logic             last_term;

    // Two guard bits are enough for up to four WIDTH-bit addends.
    always_comb begin
        sum = '0;
        for (int i = 0; i < ORDER; i++) begin
            sum = sum + {2'b00, h[i]};
        end
    end

    assign sum_ovf   = |sum[WIDTH+1:WIDTH];
    assign last_term = (cnt == CNT_W'(1));
    assign cnt_dec   = cnt - CNT_W'(1);
    assign cnt_clamp = (cnt_dec > HIST_C) ? HIST_C : cnt_dec;

    assign out_data = h[0];
    assign done     = done_r;
    assign ovf      = ovf_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        hs        = 1'b0;
        case (state)
            IDLE: begin
                if (start && len_i != '0) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_last  = last_term;
                hs        = out_ready;
                if (out_ready && last_term) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // In stop mode an overflow clamps the count so only already-valid history drains out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ORDER; i++) begin
                h[i] <= '0;
            end
            cnt    <= '0;
            mode   <= 1'b0;
            ovf_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (state == IDLE && start) begin
                ovf_r <= 1'b0;
                if (len_i != '0) begin
                    for (int i = 0; i < ORDER; i++) begin
                        h[i] <= seed_i[i*WIDTH +: WIDTH];
                    end
                    cnt  <= len_i;
                    mode <= mode_i;
                end else begin
                    done_r <= 1'b1;
                end
            end else if (hs) begin
                for (int i = 0; i < ORDER - 1; i++) begin
                    h[i] <= h[i+1];
                end
                h[ORDER-1] <= sum[WIDTH-1:0];
                if (sum_ovf && cnt > ORDER_C) begin
                    ovf_r <= 1'b1;
                end
                cnt <= (mode && sum_ovf) ? cnt_clamp : cnt_dec;
                if (last_term) begin
                    done_r <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lin_rec_gen.sv
// Scoreboard bench for lin_rec_gen: an ORDER=2 and an ORDER=3 instance (WIDTH=8)
// driven with directed and random runs, outputs checked against a sequence model.
module tb_lin_rec_gen;

    logic        clk;
    logic        rst;

    logic        start_a, mode_a, out_valid_a, out_ready_a, out_last_a, busy_a, done_a, ovf_a;
    logic [15:0] seed_a;
    logic [15:0] len_a;
    logic [7:0]  out_data_a;

    logic        start_b, mode_b, out_valid_b, out_ready_b, out_last_b, busy_b, done_b, ovf_b;
    logic [23:0] seed_b;
    logic [15:0] len_b;
    logic [7:0]  out_data_b;

    int          checks;
    int          failures;
    logic [8:0]  exp_q0[$];
    logic [8:0]  exp_q1[$];
    bit          prev_v[2], prev_r[2], prev_l[2], prev_last_hs[2];
    bit          zero_pend[2], done_seen[2], ready_rand[2];
    logic [7:0]  prev_d[2];
    int          hs_cnt[2];

    lin_rec_gen #(.WIDTH(8), .ORDER(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .seed_i(seed_a), .len_i(len_a),
        .mode_i(mode_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_data(out_data_a), .out_last(out_last_a), .busy(busy_a), .done(done_a), .ovf(ovf_a)
    );

    lin_rec_gen #(.WIDTH(8), .ORDER(3), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .seed_i(seed_b), .len_i(len_b),
        .mode_i(mode_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_data(out_data_b), .out_last(out_last_b), .busy(busy_b), .done(done_b), .ovf(ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Reference: full sequence with plain integer sums; stop mode ends before the first overflowing term.
    task automatic build_expect(input int id, input int order, input int s0, input int s1,
                                input int s2, input int len, input bit mode, output bit exp_ovf);
        int seq[$];
        int seeds[3];
        int first_of;
        int n;
        seeds[0] = s0;
        seeds[1] = s1;
        seeds[2] = s2;
        first_of = -1;
        for (int k = 0; k < len; k++) begin
            if (k < order) begin
                seq.push_back(seeds[k]);
            end else begin
                int raw;
                raw = 0;
                for (int j = 1; j <= order; j++) raw += seq[k-j];
                if (raw >= 256 && first_of < 0) first_of = k;
                seq.push_back(raw % 256);
            end
        end
        exp_ovf = (first_of >= 0);
        n = (mode && first_of >= 0) ? first_of : len;
        for (int i = 0; i < n; i++) begin
            if (id == 0) exp_q0.push_back({(i == n - 1), 8'(seq[i])});
            else         exp_q1.push_back({(i == n - 1), 8'(seq[i])});
        end
    endtask

    task automatic mon_step(input int id, input logic v, input logic r, input logic [7:0] d,
                            input logic l, input logic dn);
        logic [8:0] item;
        int qsize;
        if (dn || prev_last_hs[id] || zero_pend[id])
            check_output($sformatf("done_pulse_%0d", id), dn, prev_last_hs[id] || zero_pend[id]);
        if (dn) done_seen[id] = 1'b1;
        zero_pend[id] = 1'b0;
        if (prev_v[id] && !prev_r[id]) begin
            check_output($sformatf("valid_held_%0d", id), v, 1);
            if (v) begin
                check_output($sformatf("stall_data_%0d", id), d, prev_d[id]);
                check_output($sformatf("stall_last_%0d", id), l, prev_l[id]);
            end
        end
        prev_last_hs[id] = 1'b0;
        qsize = (id == 0) ? exp_q0.size() : exp_q1.size();
        if (v) begin
            if (qsize == 0) begin
                check_output($sformatf("spurious_valid_%0d", id), v, 0);
            end else if (r) begin
                item = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                check_output($sformatf("data_%0d", id), d, item[7:0]);
                check_output($sformatf("last_%0d", id), l, item[8]);
                hs_cnt[id]++;
                prev_last_hs[id] = item[8];
            end
        end
        prev_v[id] = v;
        prev_r[id] = r;
        prev_d[id] = d;
        prev_l[id] = l;
    endtask

    task automatic apply_stimulus(input int id, input int s0, input int s1, input int s2,
                                  input int len, input bit mode, input bit rnd_ready,
                                  output bit exp_ovf);
        build_expect(id, (id == 0) ? 2 : 3, s0, s1, s2, len, mode, exp_ovf);
        ready_rand[id] = rnd_ready;
        done_seen[id]  = 1'b0;
        @(posedge clk);
        #1;
        if (id == 0) begin
            seed_a  = {8'(s1), 8'(s0)};
            len_a   = 16'(len);
            mode_a  = mode;
            start_a = 1'b1;
        end else begin
            seed_b  = {8'(s2), 8'(s1), 8'(s0)};
            len_b   = 16'(len);
            mode_b  = mode;
            start_b = 1'b1;
        end
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        if (len == 0) zero_pend[id] = 1'b1;
        @(negedge clk);
        check_output($sformatf("first_valid_%0d", id), (id == 0) ? out_valid_a : out_valid_b,
                     (len != 0) ? 1 : 0);
    endtask

    task automatic finish_run(input int id, input bit exp_ovf);
        int n;
        n = 0;
        while (!done_seen[id] && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_output($sformatf("done_seen_%0d", id), done_seen[id], 1);
        @(negedge clk);
        check_output($sformatf("ovf_%0d", id), (id == 0) ? ovf_a : ovf_b, exp_ovf);
        check_output($sformatf("busy_idle_%0d", id), (id == 0) ? busy_a : busy_b, 0);
        check_output($sformatf("queue_drained_%0d", id), (id == 0) ? exp_q0.size() : exp_q1.size(), 0);
    endtask

    initial begin
        bit eo;
        int base;
        int n;
        checks = 0;
        failures = 0;
        rst = 1'b0;
        start_a = 1'b0; seed_a = '0; len_a = '0; mode_a = 1'b0; out_ready_a = 1'b1;
        start_b = 1'b0; seed_b = '0; len_b = '0; mode_b = 1'b0; out_ready_b = 1'b1;
        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    for (int i = 0; i < 2; i++) begin
                        prev_v[i] = 1'b0;
                        prev_r[i] = 1'b0;
                        prev_last_hs[i] = 1'b0;
                        zero_pend[i] = 1'b0;
                    end
                end else begin
                    mon_step(0, out_valid_a, out_ready_a, out_data_a, out_last_a, done_a);
                    mon_step(1, out_valid_b, out_ready_b, out_data_b, out_last_b, done_b);
                end
            end
            forever begin
                @(posedge clk);
                #1;
                out_ready_a = ready_rand[0] ? 1'($urandom_range(0, 1)) : 1'b1;
                out_ready_b = ready_rand[1] ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        join_none

        repeat (3) @(negedge clk);
        check_output("rst_valid_a", out_valid_a, 0);
        check_output("rst_busy_a", busy_a, 0);
        check_output("rst_data_a", out_data_a, 0);
        check_output("rst_done_b", done_b, 0);
        check_output("rst_ovf_b", ovf_b, 0);
        rst = 1'b1;

        apply_stimulus(0, 0, 1, 0, 10, 1'b0, 1'b0, eo);
        finish_run(0, eo);
        apply_stimulus(0, 0, 1, 0, 16, 1'b0, 1'b0, eo);
        finish_run(0, eo);
        apply_stimulus(0, 0, 1, 0, 16, 1'b1, 1'b0, eo);
        finish_run(0, eo);
        apply_stimulus(0, 42, 7, 0, 1, 1'b0, 1'b0, eo);
        finish_run(0, eo);
        apply_stimulus(0, 42, 7, 0, 0, 1'b0, 1'b0, eo);
        finish_run(0, eo);
        apply_stimulus(1, 0, 0, 1, 8, 1'b0, 1'b1, eo);
        finish_run(1, eo);
        apply_stimulus(1, 9, 8, 7, 2, 1'b1, 1'b1, eo);
        finish_run(1, eo);

        // A second start mid-run must not disturb the stream in flight.
        apply_stimulus(0, 0, 1, 0, 10, 1'b0, 1'b0, eo);
        repeat (3) @(posedge clk);
        #1;
        seed_a = {8'd7, 8'd5}; len_a = 16'd3; mode_a = 1'b1; start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        finish_run(0, eo);

        base = hs_cnt[0];
        apply_stimulus(0, 200, 100, 0, 10, 1'b0, 1'b0, eo);
        n = 0;
        while (hs_cnt[0] - base < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output("three_terms_before_reset", (hs_cnt[0] - base >= 3) ? 1 : 0, 1);
        @(posedge clk);
        #2;
        check_output("ovf_before_reset", ovf_a, 1);
        rst = 1'b0;
        #1;
        check_output("async_rst_valid", out_valid_a, 0);
        check_output("async_rst_last", out_last_a, 0);
        check_output("async_rst_busy", busy_a, 0);
        check_output("async_rst_done", done_a, 0);
        check_output("async_rst_ovf", ovf_a, 0);
        check_output("async_rst_data", out_data_a, 0);
        exp_q0.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        apply_stimulus(0, 0, 1, 0, 10, 1'b0, 1'b0, eo);
        finish_run(0, eo);

        for (int r = 0; r < 16; r++) begin
            apply_stimulus(r % 2, $urandom_range(0, 255), $urandom_range(0, 255),
                           $urandom_range(0, 255), $urandom_range(0, 20),
                           1'($urandom_range(0, 1)), 1'b1, eo);
            finish_run(r % 2, eo);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
